// File: rtl/seq_shift_sub_divider_if.sv
// Operand/result bundle for the sequential shift-subtract divider.
//
// Handshake: the requester raises start together with dividend/divisor; the
// divider accepts on a rising clk edge where start==1 and busy==0 (state IDLE or
// DONE). Operands are captured on that edge only and may change afterwards.
// While busy==1 start is ignored, with no queuing. done pulses for exactly one
// cycle when quotient/remainder/div_by_zero become valid. These results hold
// until the next operation completes. dbg_state mirrors the internal FSM state.
`timescale 1ns/1ps
interface seq_shift_sub_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, dbg_state
    );
endinterface

// File: rtl/seq_shift_sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// IDLE -> RUN (WIDTH steps) -> DONE (one-cycle done pulse) -> IDLE, with
// back-to-back acceptance straight out of DONE.
`timescale 1ns/1ps
module seq_shift_sub_divider #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_shift_sub_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    // The partial remainder never exceeds divisor-1 between steps, so its
    // top bit would always be zero; only the shifted value needs WIDTH+1 bits.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // One restoring step: shift in the next dividend bit, trial-subtract on
    // WIDTH+1 bits; no borrow out means the shifted value was >= divisor.
    always_comb begin
        w_accept   = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
        w_last     = (r_count == CW'(WIDTH - 1));
        w_shift    = {r_rem, r_q[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_div};
        w_ge       = ~w_diff[WIDTH];
        w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_q_next   = {r_q[WIDTH-2:0], w_ge};
    end

    // FSM, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_div   <= bus.divisor;
            r_q     <= bus.dividend;
            r_rem   <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
        end else if (r_state == ST_RUN) begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_quot  <= w_q_next;
                r_remo  <= w_rem_next;
                r_dbz   <= (r_div == '0);
                r_state <= ST_DONE;
            end
        end else if (r_state != ST_IDLE) begin
            // DONE without a new request, or an unused encoding.
            r_state <= ST_IDLE;
        end
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dbz;
    assign bus.dbg_state   = r_state;
endmodule
